ocram_cmd_bridge: RTL and testbench
===================================

# ocram_cmd_bridge

Valid/ready command front-end for the single-port 16K×32 on-chip RAM (registered address, unregistered q, 1-cycle read latency). Converts master command handshakes into RAM chipselect/write strobes and returns read data through a small credit-limited response FIFO with backpressure. It sits directly upstream of the on-chip RAM, between the processor's custom data interface and the RAM's slave port.

## Interface
- ADDR_W, 14, word address width (matches RAM widthad)
- DATA_W, 32, data width; BE_W = DATA_W/8 derived
- RSP_DEPTH, 4, response FIFO entries; legal 2..16; ≥3 gives one read per cycle
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_address  in  ADDR_W  word address
- cmd_byteenable  in  BE_W  write byte lanes
- cmd_writedata  in  DATA_W  write data
- rsp_valid  out  1  read data available
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_readdata  out  DATA_W  read data, in command order
- ram_chipselect, ram_write  out  1  RAM strobes
- ram_address  out  ADDR_W; ram_byteenable  out  BE_W; ram_writedata  out  DATA_W
- ram_clken  out  1  constant 1 (0 while reset asserted)
- ram_readdata  in  DATA_W  RAM q
- stat_rd_count, stat_wr_count  out  16  accepted-command counters (see Configuration)

## Operation
- State: inflight (1 bit, read issued last edge), occ (0..RSP_DEPTH), FIFO storage, rd/wr pointers.
- credit = (occ + inflight) < RSP_DEPTH, from registered state only; no combinational rsp_ready→cmd_ready path.
- cmd_ready = credit & ~reset, identical for reads and writes (writes stall with reads; decided for simplicity).
- Accept: ram_chipselect = cmd_valid & cmd_ready; ram_write = accept & cmd_write; ram_address/byteenable/writedata = cmd_* passthrough (combinational).
- Read accept at edge E: inflight←1; otherwise inflight←0.
- If inflight=1 during a cycle, ram_readdata is pushed into FIFO at that cycle's ending edge.
- Pop when rsp_valid & rsp_ready; rsp_valid = (occ≠0); rsp_readdata = FIFO head.
- Simultaneous push and pop: occ unchanged, both pointers advance. Push at occ=RSP_DEPTH cannot occur (credit invariant occ+inflight ≤ RSP_DEPTH); bench asserts it.
- Pointers wrap modulo RSP_DEPTH (non-power-of-two supported by explicit compare-and-clear).
- Write responses are not generated. Read after write to same address: write at E, read accepted later sees new data; same-cycle conflicts impossible (one command per cycle).

## Timing
- Reset values: rsp_valid 0, rsp_readdata 0, occ 0, inflight 0, pointers 0, stat counters 0; cmd_ready, ram_chipselect, ram_write, ram_clken 0 while reset high.
- Reset mid-operation: in-flight read and all FIFO entries discarded immediately; no response emitted for them.
- Read latency: accepted cycle N → rsp_valid cycle N+2 (FIFO empty case).
- Throughput: with rsp_ready=1 and RSP_DEPTH≥3, one read per cycle sustained; RSP_DEPTH=2 gives 2 reads per 3 cycles.
- Writes: RAM updated at the accept edge; zero-cycle acceptance.
- rsp_valid, once high, stays high with stable rsp_readdata until popped.

## Configuration
- OCRAM_BRIDGE_STATS_EN defined: stat_rd_count / stat_wr_count increment on each accepted read / write, saturating at 16'hFFFF, cleared by reset.
- Undefined: both ports present but tied to 0; no counter logic.

## Test plan
- Write 32'hDEADBEEF to addr 0x0010 byteenable 4'hF, then read 0x0010 → rsp_readdata 32'hDEADBEEF exactly 2 cycles after read accept.
- Partial write 32'h11223344 be 4'b0101 over 32'hFFFFFFFF at 0x3FFF → read returns 32'hFF22FF44.
- 8 back-to-back reads, rsp_ready=1, RSP_DEPTH=4 → cmd_ready never drops, 8 responses on 8 consecutive cycles, in order.
- rsp_ready=0, continuous reads → exactly 4 accepted, then cmd_ready=0; occ=4; release rsp_ready → 4 correct responses, accepting resumes, no loss or duplicate.
- Assert reset with occ=2 and inflight=1 → rsp_valid 0 immediately, no stale response after deassert; next read returns fresh data at N+2.
- With OCRAM_BRIDGE_STATS_EN: 3 writes + 5 reads → stat_wr_count=3, stat_rd_count=5; without macro both read 0.

Source files
------------

// File: rtl/ocram_cmd_bridge.sv
// Valid/ready command front-end for a single-port on-chip RAM with 1-cycle read latency.
// Define OCRAM_BRIDGE_STATS_EN to enable the accepted-command statistics counters.
module ocram_cmd_bridge #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 32,
  parameter int RSP_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_address,
  input  logic [DATA_W/8-1:0]   cmd_byteenable,
  input  logic [DATA_W-1:0]     cmd_writedata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_readdata,
  output logic                  ram_chipselect,
  output logic                  ram_write,
  output logic [ADDR_W-1:0]     ram_address,
  output logic [DATA_W/8-1:0]   ram_byteenable,
  output logic [DATA_W-1:0]     ram_writedata,
  output logic                  ram_clken,
  input  logic [DATA_W-1:0]     ram_readdata,
  output logic [15:0]           stat_rd_count,
  output logic [15:0]           stat_wr_count
);

  localparam int OCC_W = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [OCC_W:0]   DEPTH_C  = (OCC_W + 1)'(RSP_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RSP_DEPTH - 1);

  logic              r_inflight;
  logic [OCC_W-1:0]  r_occ;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [DATA_W-1:0] r_fifo [RSP_DEPTH];

  logic w_credit;
  logic w_accept;
  logic w_rd_accept;
  logic w_push;
  logic w_pop;

  // Explicit compare-and-clear so non-power-of-two depths wrap correctly.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit counts the read already in the RAM, so a slot is reserved before data returns.
  assign w_credit    = ({1'b0, r_occ} + {{OCC_W{1'b0}}, r_inflight}) < DEPTH_C;
  assign cmd_ready   = w_credit & ~reset;
  assign w_accept    = cmd_valid & cmd_ready;
  assign w_rd_accept = w_accept & ~cmd_write;
  assign w_push      = r_inflight;
  assign w_pop       = rsp_valid & rsp_ready;

  assign ram_chipselect = w_accept;
  assign ram_write      = w_accept & cmd_write;
  assign ram_address    = cmd_address;
  assign ram_byteenable = cmd_byteenable;
  assign ram_writedata  = cmd_writedata;
  assign ram_clken      = ~reset;

  assign rsp_valid    = (r_occ != '0);
  assign rsp_readdata = rsp_valid ? r_fifo[r_rd_ptr] : '0;

  // Stage p1: read issued last edge; RAM q is valid this cycle and lands in the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inflight <= 1'b0;
      r_occ      <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_inflight <= w_rd_accept;
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      if (w_push && !w_pop)
        r_occ <= r_occ + OCC_W'(1);
      else if (!w_push && w_pop)
        r_occ <= r_occ - OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= ram_readdata;
  end

`ifdef OCRAM_BRIDGE_STATS_EN
  logic [15:0] r_rd_count;
  logic [15:0] r_wr_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else begin
      if (w_rd_accept && (r_rd_count != 16'hFFFF))
        r_rd_count <= r_rd_count + 16'd1;
      if (ram_write && (r_wr_count != 16'hFFFF))
        r_wr_count <= r_wr_count + 16'd1;
    end
  end

  assign stat_rd_count = r_rd_count;
  assign stat_wr_count = r_wr_count;
`else
  assign stat_rd_count = '0;
  assign stat_wr_count = '0;
`endif

endmodule

// File: tb/tb_ocram_cmd_bridge.sv
// Self-checking bench for ocram_cmd_bridge: directed vector table, corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_ocram_cmd_bridge;
  localparam int ADDR_W    = 14;
  localparam int DATA_W    = 32;
  localparam int BE_W      = 4;
  localparam int RSP_DEPTH = 4;
  localparam int WORDS     = 16384;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_address = '0;
  logic [BE_W-1:0]   cmd_byteenable = '0;
  logic [DATA_W-1:0] cmd_writedata = '0;
  logic              rsp_ready = 1'b0;
  logic              cmd_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_readdata;
  logic              ram_chipselect;
  logic              ram_write;
  logic [ADDR_W-1:0] ram_address;
  logic [BE_W-1:0]   ram_byteenable;
  logic [DATA_W-1:0] ram_writedata;
  logic              ram_clken;
  logic [DATA_W-1:0] ram_readdata;
  logic [15:0]       stat_rd_count;
  logic [15:0]       stat_wr_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  ocram_cmd_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_byteenable(cmd_byteenable), .cmd_writedata(cmd_writedata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_readdata(rsp_readdata),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write), .ram_address(ram_address),
    .ram_byteenable(ram_byteenable), .ram_writedata(ram_writedata), .ram_clken(ram_clken),
    .ram_readdata(ram_readdata),
    .stat_rd_count(stat_rd_count), .stat_wr_count(stat_wr_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_val(input int a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RAM model: registered address, unregistered q, byte-lane writes at the accept edge.
  logic [31:0]       ram_mem [WORDS];
  logic [ADDR_W-1:0] ram_addr_q = '0;
  bit                ram_init_done = 1'b0;

  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int i = 0; i < WORDS; i++) ram_mem[i] <= init_val(i);
      ram_init_done <= 1'b1;
    end else if (ram_clken && ram_chipselect) begin
      ram_addr_q <= ram_address;
      if (ram_write)
        for (int b = 0; b < BE_W; b++)
          if (ram_byteenable[b]) ram_mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
    end
  end
  assign ram_readdata = ram_mem[ram_addr_q];

  // Reference model: outstanding reads form an ordered queue of {data, first visible cycle}.
  typedef struct {
    logic [31:0] data;
    int          avail;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [31:0] ref_mem [WORDS];
  bit          ref_init = 1'b0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;

  always @(negedge clk) begin
    bit          exp_ready;
    bit          exp_vld;
    logic [15:0] e_rd;
    logic [15:0] e_wr;
    rsp_t        r;
    if (!ref_init) begin
      for (int i = 0; i < WORDS; i++) ref_mem[i] = init_val(i);
      ref_init = 1'b1;
    end
    if (reset) begin
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_readdata", rsp_readdata, 0);
      chk("rst_ram_clken", ram_clken, 0);
      chk("rst_ram_cs", ram_chipselect, 0);
      chk("rst_ram_write", ram_write, 0);
      exp_q.delete();
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      exp_ready = (exp_q.size() < RSP_DEPTH);
      exp_vld   = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
`ifdef OCRAM_BRIDGE_STATS_EN
      e_rd = (rd_cnt > 65535) ? 16'hFFFF : 16'(rd_cnt);
      e_wr = (wr_cnt > 65535) ? 16'hFFFF : 16'(wr_cnt);
`else
      e_rd = '0;
      e_wr = '0;
`endif
      chk("sb_cmd_ready", cmd_ready, exp_ready);
      chk("sb_rsp_valid", rsp_valid, exp_vld);
      if (exp_vld) chk("sb_rsp_readdata", rsp_readdata, exp_q[0].data);
      chk("sb_ram_cs", ram_chipselect, cmd_valid & exp_ready);
      chk("sb_ram_write", ram_write, cmd_valid & exp_ready & cmd_write);
      chk("sb_ram_addr", ram_address, cmd_address);
      chk("sb_ram_be", ram_byteenable, cmd_byteenable);
      chk("sb_ram_wdata", ram_writedata, cmd_writedata);
      chk("sb_ram_clken", ram_clken, 1);
      chk("sb_stat_rd", stat_rd_count, e_rd);
      chk("sb_stat_wr", stat_wr_count, e_wr);
      chk("push_at_full", (dut.r_inflight && (int'(dut.r_occ) == RSP_DEPTH)), 0);
      if (exp_vld && rsp_ready) void'(exp_q.pop_front());
      if (cmd_valid && exp_ready) begin
        if (cmd_write) begin
          for (int b = 0; b < BE_W; b++)
            if (cmd_byteenable[b]) ref_mem[cmd_address][8*b +: 8] = cmd_writedata[8*b +: 8];
          wr_cnt++;
        end else begin
          r.data  = ref_mem[cmd_address];
          r.avail = cyc + 2;
          exp_q.push_back(r);
          rd_cnt++;
        end
      end
    end
  end

  // Present one command and hold it until accepted; returns the accept cycle.
  task automatic issue(input bit wr, input logic [ADDR_W-1:0] a, input logic [BE_W-1:0] be,
                       input logic [31:0] d, output int acc);
    bit ok;
    ok  = 1'b0;
    acc = -1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_address = a; cmd_byteenable = be; cmd_writedata = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; acc = cyc; end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    chk("issue_accepted", ok, 1);
  endtask

  typedef struct {
    bit          wr;
    logic [13:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t        vec[8];
  int          acc;
  int          nacc, nrsp, nv, first, last, c0;
  logic [31:0] tmp;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tmp = init_val(32'h123);
    vec[0] = '{1'b1, 14'h0010, 4'hF,    32'hDEADBEEF, 32'h0};
    vec[1] = '{1'b1, 14'h3FFF, 4'hF,    32'hFFFFFFFF, 32'h0};
    vec[2] = '{1'b1, 14'h3FFF, 4'b0101, 32'h11223344, 32'h0};
    vec[3] = '{1'b0, 14'h0010, 4'h0,    32'h0,        32'hDEADBEEF};
    vec[4] = '{1'b0, 14'h3FFF, 4'h0,    32'h0,        32'hFF22FF44};
    vec[5] = '{1'b0, 14'h0123, 4'h0,    32'h0,        tmp};
    vec[6] = '{1'b1, 14'h0123, 4'b1000, 32'hABCD1234, 32'h0};
    vec[7] = '{1'b0, 14'h0123, 4'h0,    32'h0,        {8'hAB, tmp[23:0]}};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;

    // Vector table: writes, then reads checked for data and exact two-cycle latency.
    for (int i = 0; i < 8; i++) begin
      issue(vec[i].wr, vec[i].addr, vec[i].be, vec[i].wdata, acc);
      if (!vec[i].wr) begin
        @(negedge clk);
        chk($sformatf("tbl_lat1_valid[%0d]", i), rsp_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk($sformatf("tbl_lat2_valid[%0d]", i), rsp_valid, 1);
        chk($sformatf("tbl_rdata[%0d]", i), rsp_readdata, vec[i].exp);
        @(posedge clk); #1;
      end
    end

    // Eight back-to-back reads with the consumer always ready.
    nv = 0; first = -1; last = -1; c0 = 0;
    cmd_write = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cmd_valid   = (i < 8);
      cmd_address = ADDR_W'(32'h200 + i);
      @(negedge clk);
      if (i < 8) begin
        chk("b2b_ready", cmd_ready, 1);
        if (i == 0) c0 = cyc;
      end
      if (rsp_valid) begin
        chk("b2b_data", rsp_readdata, init_val(32'h200 + nv));
        if (first < 0) first = cyc;
        last = cyc;
        nv++;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    chk("b2b_count", nv, 8);
    chk("b2b_first", first, c0 + 2);
    chk("b2b_last", last, c0 + 9);

    // Backpressure: credits run out at RSP_DEPTH, then drain and resume.
    rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b0; nacc = 0;
    for (int i = 0; i < 8; i++) begin
      cmd_address = ADDR_W'(32'h300 + nacc);
      @(negedge clk);
      if (cmd_ready) nacc++;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    chk("bp_accepts", nacc, 4);
    @(negedge clk);
    chk("bp_ready_low", cmd_ready, 0);
    chk("bp_valid_held", rsp_valid, 1);
    chk("bp_head", rsp_readdata, init_val(32'h300));
    chk("bp_occ", dut.r_occ, 4);
    @(posedge clk); #1;
    rsp_ready = 1'b1; nrsp = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        chk("bp_rsp_data", rsp_readdata, init_val(32'h300 + nrsp));
        nrsp++;
      end
      @(posedge clk); #1;
    end
    chk("bp_rsp_count", nrsp, 4);
    issue(1'b0, 14'h0304, 4'h0, 32'h0, acc);
    repeat (4) @(posedge clk);
    #1;

    // Reset with two queued responses and one read in flight.
    rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmd_address = ADDR_W'(32'h400 + i);
      @(negedge clk);
      chk("rst_pre_accept", cmd_ready, 1);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_async_valid", rsp_valid, 0);
    chk("rst_async_ready", cmd_ready, 0);
    chk("rst_async_clken", ram_clken, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_stale", rsp_valid, 0);
      @(posedge clk); #1;
    end
    issue(1'b0, 14'h0010, 4'h0, 32'h0, acc);
    @(negedge clk);
    chk("rst_fresh_lat1", rsp_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_fresh_valid", rsp_valid, 1);
    chk("rst_fresh_data", rsp_readdata, 32'hDEADBEEF);
    @(posedge clk); #1;

    // Statistics: 3 writes and 5 reads after a fresh reset.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) issue(1'b1, ADDR_W'(32'h500 + i), 4'hF, $urandom, acc);
    for (int i = 0; i < 5; i++) issue(1'b0, ADDR_W'(32'h500 + (i % 3)), 4'h0, 32'h0, acc);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
`ifdef OCRAM_BRIDGE_STATS_EN
    chk("stat_wr_final", stat_wr_count, 3);
    chk("stat_rd_final", stat_rd_count, 5);
`else
    chk("stat_wr_tied", stat_wr_count, 0);
    chk("stat_rd_tied", stat_rd_count, 0);
`endif
    @(posedge clk); #1;

    // Randomized traffic, checked cycle by cycle by the reference model.
    for (int i = 0; i < 400; i++) begin
      cmd_valid = ($urandom_range(0, 9) < 6);
      cmd_write = ($urandom_range(0, 9) < 4);
      case ($urandom_range(0, 3))
        0:       cmd_address = 14'h0010;
        1:       cmd_address = 14'h3FFF;
        default: cmd_address = ADDR_W'(32'h600 + $urandom_range(0, 7));
      endcase
      cmd_byteenable = BE_W'($urandom);
      cmd_writedata  = $urandom;
      rsp_ready      = ($urandom_range(0, 9) < 7);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    @(negedge clk);
    chk("final_empty", rsp_valid, 0);
    chk("final_model_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
